// File: rtl/buzzer_arbiter.sv
// Piezo buzzer arbiter: three prioritized tone requesters (err > ok > key) with
// pre-emption, retrigger and a one-deep pending slot. Optional macro BUZZER_MUTE_EN adds a mute input.
module buzzer_arbiter #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned KEY_HALF = 50000,
  parameter int unsigned KEY_LEN  = 10000000,
  parameter int unsigned OK_HALF  = 25000,
  parameter int unsigned OK_LEN   = 30000000,
  parameter int unsigned ERR_HALF = 100000,
  parameter int unsigned ERR_SEG  = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_key,
  input  logic       req_ok,
  input  logic       req_err,
`ifdef BUZZER_MUTE_EN
  input  logic       mute,
`endif
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done,
  output logic       dropped
);

  typedef enum logic [2:0] {
    IDLE, PLAY_KEY, PLAY_OK, ERR_ON1, ERR_GAP, ERR_ON2
  } state_t;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_KEY  = 2'd1;
  localparam logic [1:0] ID_OK   = 2'd2;
  localparam logic [1:0] ID_ERR  = 2'd3;

  state_t           state, state_nx;
  logic [CNT_W-1:0] tone_cnt, tone_nx;
  logic [CNT_W-1:0] half_cnt, half_nx;
  logic [CNT_W-1:0] len_m1, half_m1;
  logic             buzz_q, buzz_nx;
  logic [1:0]       pend, pend_nx;
  logic             done_nx, drop_nx;
  logic [1:0]       cur_id, acc_id;
  logic [2:0]       new_mask, cand, rem;
  logic             start, preempt, retrig;

  function automatic logic [1:0] top_id(input logic [2:0] m);
    if (m[2])      return ID_ERR;
    else if (m[1]) return ID_OK;
    else if (m[0]) return ID_KEY;
    else           return ID_NONE;
  endfunction

  function automatic logic [2:0] id_mask(input logic [1:0] id);
    case (id)
      ID_KEY:  return 3'b001;
      ID_OK:   return 3'b010;
      ID_ERR:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Ids strictly lower in priority than the given id.
  function automatic logic [2:0] below_mask(input logic [1:0] id);
    case (id)
      ID_ERR:  return 3'b011;
      ID_OK:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] state_id(input state_t s);
    case (s)
      PLAY_KEY:                  return ID_KEY;
      PLAY_OK:                   return ID_OK;
      ERR_ON1, ERR_GAP, ERR_ON2: return ID_ERR;
      default:                   return ID_NONE;
    endcase
  endfunction

  // Arbitration: the winner is the highest of {playing tone, new requests, pending};
  // the best of what remains below it becomes the pending tone.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cur_id   = state_id(state);
    new_mask = {req_err, req_ok, req_key};
    cand     = new_mask | id_mask(pend);
    acc_id   = top_id(cand);
    if (cur_id > acc_id) acc_id = cur_id;
    rem      = cand & below_mask(acc_id);
    preempt  = (cur_id != ID_NONE) && (acc_id != cur_id);
    retrig   = (cur_id != ID_NONE) && ((new_mask & id_mask(cur_id)) != 3'b000);
    start    = (acc_id != cur_id) || retrig;

    state_nx = state;
    tone_nx  = tone_cnt;
    half_nx  = half_cnt;
    buzz_nx  = buzz_q;
    pend_nx  = top_id(rem);
    done_nx  = 1'b0;
    drop_nx  = preempt | (rem[0] & rem[1]) | (rem[0] & rem[2]) | (rem[1] & rem[2]);

    case (state)
      PLAY_KEY: begin len_m1 = CNT_W'(KEY_LEN - 1); half_m1 = CNT_W'(KEY_HALF - 1); end
      PLAY_OK:  begin len_m1 = CNT_W'(OK_LEN - 1);  half_m1 = CNT_W'(OK_HALF - 1);  end
      default:  begin len_m1 = CNT_W'(ERR_SEG - 1); half_m1 = CNT_W'(ERR_HALF - 1); end
    endcase

    if (start) begin
      tone_nx = '0;
      half_nx = '0;
      buzz_nx = 1'b1;
      case (acc_id)
        ID_ERR:  state_nx = ERR_ON1;
        ID_OK:   state_nx = PLAY_OK;
        default: state_nx = PLAY_KEY;
      endcase
    end else if (state != IDLE) begin
      if (tone_cnt == len_m1) begin
        tone_nx = '0;
        half_nx = '0;
        case (state)
          ERR_ON1: begin state_nx = ERR_GAP; buzz_nx = 1'b0; end
          ERR_GAP: begin state_nx = ERR_ON2; buzz_nx = 1'b1; end
          default: begin state_nx = IDLE; buzz_nx = 1'b0; done_nx = 1'b1; end
        endcase
      end else begin
        tone_nx = tone_cnt + CNT_W'(1);
        if (state == ERR_GAP) begin
          half_nx = '0;
          buzz_nx = 1'b0;
        end else if (half_cnt == half_m1) begin
          half_nx = '0;
          buzz_nx = ~buzz_q;
        end else begin
          half_nx = half_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state    <= IDLE;
      tone_cnt <= '0;
      half_cnt <= '0;
      buzz_q   <= 1'b0;
      pend     <= ID_NONE;
      done     <= 1'b0;
      dropped  <= 1'b0;
    end else begin
      state    <= state_nx;
      tone_cnt <= tone_nx;
      half_cnt <= half_nx;
      buzz_q   <= buzz_nx;
      pend     <= pend_nx;
      done     <= done_nx;
      dropped  <= drop_nx;
    end
  end

  assign busy      = (state != IDLE);
  assign active_id = state_id(state);

`ifdef BUZZER_MUTE_EN
  assign buzzer = buzz_q & ~mute;
`else
  assign buzzer = buzz_q;
`endif

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter with short tone parameters; define BUZZER_MUTE_EN
// on both files to also exercise the mute input.
module tb_buzzer_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_key = 1'b0, req_ok = 1'b0, req_err = 1'b0;
  logic       buzzer, busy, done, dropped;
  logic [1:0] active_id;
`ifdef BUZZER_MUTE_EN
  logic       mute = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  buzzer_arbiter #(
    .CNT_W(32), .KEY_HALF(2), .KEY_LEN(8), .OK_HALF(1), .OK_LEN(6),
    .ERR_HALF(3), .ERR_SEG(6)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_key(req_key), .req_ok(req_ok), .req_err(req_err),
`ifdef BUZZER_MUTE_EN
    .mute(mute),
`endif
    .buzzer(buzzer), .busy(busy), .active_id(active_id),
    .done(done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Compare all five outputs against expected values in one go.
  task automatic expect_out(input string tag, input int cyc, input logic b, input logic bz,
                            input logic [1:0] id, input logic d, input logic dr);
    n_checks++;
    if ({buzzer, busy, active_id, done, dropped} !== {b, bz, id, d, dr}) begin
      n_fail++;
      $display("FAIL %s cyc%0d: got buzzer=%b busy=%b id=%0d done=%b dropped=%b, want %b %b %0d %b %b",
               tag, cyc, buzzer, busy, active_id, done, dropped, b, bz, id, d, dr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    expect_out("reset", 0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(2);
    expect_out("post_reset", 0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_key_tone();
    logic [7:0] pat;
    pat = 8'b11001100;
    req_key = 1'b1; tick(); req_key = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_out("key_play", i, pat[7-i], 1'b1, 2'd1, 1'b0, 1'b0);
      tick();
    end
    expect_out("key_done", 8, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    tick();
    expect_out("key_after", 9, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_err_tone();
    logic [17:0] pat;
    pat = 18'b111000_000000_111000;
    req_err = 1'b1; tick(); req_err = 1'b0;
    for (int i = 0; i < 18; i++) begin
      expect_out("err_play", i, pat[17-i], 1'b1, 2'd3, 1'b0, 1'b0);
      tick();
    end
    expect_out("err_done", 18, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_preempt();
    req_ok = 1'b1; tick(); req_ok = 1'b0;
    expect_out("ok_start", 6, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    expect_out("ok_toggle", 7, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    expect_out("ok_toggle", 8, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    req_err = 1'b1; tick(); req_err = 1'b0;
    expect_out("preempt", 9, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1);
    tick();
    expect_out("preempt_next", 10, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    idle(16);
    expect_out("preempt_last", 26, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    tick();
    expect_out("preempt_done", 27, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_pending();
    req_key = 1'b1; req_ok = 1'b1; req_err = 1'b1;
    tick();
    req_key = 1'b0; req_ok = 1'b0; req_err = 1'b0;
    expect_out("all_accept", 4, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1);
    idle(18);
    expect_out("all_err_done", 22, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    tick();
    expect_out("pend_start", 23, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    idle(5);
    expect_out("pend_last", 28, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    expect_out("pend_done", 29, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(3);
    expect_out("no_key_after", 32, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_retrigger();
    req_key = 1'b1; tick(); req_key = 1'b0;
    idle(3);
    expect_out("retrig_before", 3, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    req_key = 1'b1; tick(); req_key = 1'b0;
    expect_out("retrig", 0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    idle(7);
    expect_out("retrig_last", 7, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    tick();
    expect_out("retrig_done", 8, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_tone();
    req_ok = 1'b1; tick(); req_ok = 1'b0;
    req_key = 1'b1; tick(); req_key = 1'b0;
    expect_out("key_pending", 1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0; tick();
    expect_out("mid_reset", 4, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_out("reset_no_pend", i, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    end
  endtask

`ifdef BUZZER_MUTE_EN
  task automatic test_mute();
    mute = 1'b1;
    req_key = 1'b1; tick(); req_key = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_out("mute_play", i, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
      tick();
    end
    expect_out("mute_done", 8, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    mute = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_key_tone();
    idle(2);
    test_err_tone();
    idle(2);
    test_preempt();
    idle(2);
    test_pending();
    test_retrigger();
    idle(2);
    test_reset_mid_tone();
`ifdef BUZZER_MUTE_EN
    test_mute();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
